dip_debounce: RTL and testbench
===============================

# dip_debounce

Input conditioner between the eight raw 8-bit DIP-switch banks on the board pins and the `dip_switch` bus peripheral. Each bank is synchronised into `clk` with a two-flop synchroniser, then debounced as an 8-bit word. A new bank value is forwarded only after it has held unchanged for `DEBOUNCE_CYCLES` consecutive cycles. This keeps glitches from reaching the peripheral's change-detect interrupt.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000 (10 ms at 25 MHz): consecutive stable cycles required before a bank updates. Legal range is 2 to 2^24−1.

Ports:
- `clk`  input  1  system clock; all logic on rising edge
- `reset`  input  1  synchronous, active-low reset (`reset==0` resets on the next rising `clk`)
- `raw_sw0` … `raw_sw7`  input  8 each  asynchronous pin levels; switch on = 0
- `dip_switch0` … `dip_switch7`  output  8 each  debounced bank values; registered; drive the same-named peripheral inputs
- `sw_changed`  output  1  (only with `DIP_DEBOUNCE_STROBE_EN`) one-cycle pulse when any bank updates
- `sw_changed_mask`  output  8  (only with `DIP_DEBOUNCE_STROBE_EN`) bit i = bank i updated this cycle

## Operation
Each bank i has identical, fully independent state:
- `s1`, `s2`: synchroniser flops.
- `prev`: `s2` from the previous cycle.
- `stable`: the value driven on `dip_switchi`.
- `cnt`: width ceil(log2(DEBOUNCE_CYCLES)), saturating never needed.

Per rising edge, when `reset==1`:
- `s1<=raw`, `s2<=s1`, `prev<=s2`.
- If `s2==stable`: `cnt<=0`. The candidate is abandoned, so a bounce back to the old value cancels.
- Else if `s2!=prev`: `cnt<=0`. A new candidate has appeared; a change of candidate mid-count restarts the count.
- Else if `cnt==DEBOUNCE_CYCLES-1`: `stable<=s2`, `cnt<=0`, and the bank's update flag is set for this edge.
- Else: `cnt<=cnt+1`.

General rules:
- Comparison is whole-word: any bit difference counts as a difference.
- Multiple banks may update on the same edge; all such updates appear in the mask together.
- No arithmetic wraps. `cnt` never exceeds `DEBOUNCE_CYCLES-1`.

## Timing
Reset (`reset==0` at an edge) loads the following values:
- `s1`, `s2`, `prev`, `stable` all = 8'hFF (all switches off).
- `cnt` = 0.
- `sw_changed`=0 and `sw_changed_mask`=0.

Reset mid-count discards the candidate. After reset releases, banks whose pins are not 8'hFF update after the normal latency, and this update is reported as a change.

Latency: let raw be sampled new at edge E0 and held. Then:
- `s2` is new after E1.
- The count restarts at E2.
- `dip_switchi` changes at edge E(DEBOUNCE_CYCLES+2).

Glitch rejection:
- A pulse that differs from `stable` for fewer than DEBOUNCE_CYCLES+1 synchronised cycles never reaches the output.
- A bank toggling continuously never updates.

Strobe timing:
- `sw_changed`/mask are registered and go high on the same edge `stable` updates.
- They are high for exactly one cycle, unless the same bank updates on consecutive qualifying edges, which is impossible since DEBOUNCE_CYCLES≥2.

## Configuration
- `DIP_DEBOUNCE_STROBE_EN` defined: `sw_changed` and `sw_changed_mask` ports and their registers exist, behaving as described above.
- Not defined: both ports and their registers are absent. Debounced outputs are unaffected. The peripheral's own change detection is the sole change indication.

## Test plan
All cases use DEBOUNCE_CYCLES=4, and edge 0 is the first edge after `reset` goes high.
- Reset: hold `reset=0` for 3 edges with arbitrary raw values. Required: all `dip_switchi`=8'hFF and `sw_changed`=0.
- Clean change: set `raw_sw3`=8'hA5 before E0 and hold. Required:
  - `dip_switch3` stays 8'hFF through E5 and becomes 8'hA5 at E6.
  - `sw_changed`=1 and mask=8'h08 for exactly the E6–E7 cycle.
- Bounce rejection: `raw_sw0`=8'h00 for 3 cycles, back to 8'hFF for 1 cycle, then 8'h00 held. Required: `dip_switch0` updates only 6 edges after the final transition, with no intermediate update.
- Candidate change mid-count: `raw_sw5` goes 8'h0F for 3 cycles, then 8'hF0 held. Required: `dip_switch5` never shows 8'h0F and becomes 8'hF0 at edge +6 from the 8'hF0 sample.
- Simultaneous banks: `raw_sw1` and `raw_sw7` both change at E0. Required: both outputs update at E6 and mask=8'h82 in a single pulse.
- Reset mid-count: change `raw_sw2`, assert `reset=0` at edge 3, release. Required:
  - Outputs are 8'hFF with no strobe during reset.
  - `dip_switch2` updates 6 edges after release.

Source files
------------

// File: rtl/dip_debounce.sv
// Two-flop synchroniser and whole-word debouncer for eight 8-bit DIP-switch banks.
// Define DIP_DEBOUNCE_STROBE_EN to add the registered sw_changed / sw_changed_mask strobe.
module dip_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] raw_sw0,
    input  logic [7:0] raw_sw1,
    input  logic [7:0] raw_sw2,
    input  logic [7:0] raw_sw3,
    input  logic [7:0] raw_sw4,
    input  logic [7:0] raw_sw5,
    input  logic [7:0] raw_sw6,
    input  logic [7:0] raw_sw7,
    output logic [7:0] dip_switch0,
    output logic [7:0] dip_switch1,
    output logic [7:0] dip_switch2,
    output logic [7:0] dip_switch3,
    output logic [7:0] dip_switch4,
    output logic [7:0] dip_switch5,
    output logic [7:0] dip_switch6,
    output logic [7:0] dip_switch7
`ifdef DIP_DEBOUNCE_STROBE_EN
    ,
    output logic       sw_changed,
    output logic [7:0] sw_changed_mask
`endif
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [7:0] raw [8];
    logic [7:0] debounced [8];
    logic [7:0] bank_update;

    assign raw[0] = raw_sw0;
    assign raw[1] = raw_sw1;
    assign raw[2] = raw_sw2;
    assign raw[3] = raw_sw3;
    assign raw[4] = raw_sw4;
    assign raw[5] = raw_sw5;
    assign raw[6] = raw_sw6;
    assign raw[7] = raw_sw7;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_bank
            logic [7:0]    s1;
            logic [7:0]    s2;
            logic [7:0]    prev;
            logic [7:0]    stable;
            logic [CW-1:0] cnt;

            // A bank commits when its candidate has survived the full count unchanged.
            assign bank_update[i] = (s2 != stable) && (s2 == prev) && (cnt == CNT_MAX);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    s1     <= 8'hFF;
                    s2     <= 8'hFF;
                    prev   <= 8'hFF;
                    stable <= 8'hFF;
                    cnt    <= '0;
                end else begin
                    s1   <= raw[i];
                    s2   <= s1;
                    prev <= s2;
                    if (s2 == stable) begin
                        cnt <= '0;
                    end else if (s2 != prev) begin
                        cnt <= '0;
                    end else if (bank_update[i]) begin
                        stable <= s2;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
            end

            assign debounced[i] = stable;
        end
    endgenerate

    assign dip_switch0 = debounced[0];
    assign dip_switch1 = debounced[1];
    assign dip_switch2 = debounced[2];
    assign dip_switch3 = debounced[3];
    assign dip_switch4 = debounced[4];
    assign dip_switch5 = debounced[5];
    assign dip_switch6 = debounced[6];
    assign dip_switch7 = debounced[7];

`ifdef DIP_DEBOUNCE_STROBE_EN
    // Registered alongside stable, so the pulse lines up with the new bank values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_changed      <= 1'b0;
            sw_changed_mask <= 8'h00;
        end else begin
            sw_changed      <= |bank_update;
            sw_changed_mask <= bank_update;
        end
    end
`endif

endmodule

// File: tb/tb_dip_debounce.sv
// Directed and randomized bench for dip_debounce with DEBOUNCE_CYCLES=4, checked
// against a run-length reference model; strobe checks follow DIP_DEBOUNCE_STROBE_EN.
module tb_dip_debounce;

    localparam int DC = 4;

    logic       clk;
    logic       reset;
    logic [7:0] raw [8];
    logic [7:0] dip_out [8];
`ifdef DIP_DEBOUNCE_STROBE_EN
    logic       sw_changed;
    logic [7:0] sw_changed_mask;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: value in play at each edge is the raw sample from two edges earlier;
    // a bank takes that value once it has been seen DC+1 edges in a row and differs from the output.
    logic [7:0] h1 [8];
    logic [7:0] h2 [8];
    logic [7:0] last_v [8];
    logic [7:0] exp_stable [8];
    int         run_len [8];
    logic [7:0] exp_mask;

    dip_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .raw_sw0(raw[0]),
        .raw_sw1(raw[1]),
        .raw_sw2(raw[2]),
        .raw_sw3(raw[3]),
        .raw_sw4(raw[4]),
        .raw_sw5(raw[5]),
        .raw_sw6(raw[6]),
        .raw_sw7(raw[7]),
        .dip_switch0(dip_out[0]),
        .dip_switch1(dip_out[1]),
        .dip_switch2(dip_out[2]),
        .dip_switch3(dip_out[3]),
        .dip_switch4(dip_out[4]),
        .dip_switch5(dip_out[5]),
        .dip_switch6(dip_out[6]),
        .dip_switch7(dip_out[7])
`ifdef DIP_DEBOUNCE_STROBE_EN
        ,
        .sw_changed(sw_changed),
        .sw_changed_mask(sw_changed_mask)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int bank, input logic [7:0] value);
        raw[bank] = value;
    endtask

    task automatic modelEdge();
        logic [7:0] v;
        exp_mask = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (!reset) begin
                h1[b]         = 8'hFF;
                h2[b]         = 8'hFF;
                last_v[b]     = 8'hFF;
                exp_stable[b] = 8'hFF;
                run_len[b]    = 1;
            end else begin
                v     = h2[b];
                h2[b] = h1[b];
                h1[b] = raw[b];
                run_len[b] = (v == last_v[b]) ? run_len[b] + 1 : 1;
                last_v[b]  = v;
                if (v != exp_stable[b] && run_len[b] == DC + 1) begin
                    exp_stable[b] = v;
                    exp_mask[b]   = 1'b1;
                end
            end
        end
    endtask

    task automatic checkOutput();
        for (int b = 0; b < 8; b++)
            checkValue($sformatf("dip_switch%0d", b), dip_out[b], exp_stable[b]);
`ifdef DIP_DEBOUNCE_STROBE_EN
        checkValue("sw_changed", {7'd0, sw_changed}, {7'd0, |exp_mask});
        checkValue("sw_changed_mask", sw_changed_mask, exp_mask);
`endif
    endtask

    task automatic stepEdge();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        reset = 1'b0;
        for (int b = 0; b < 8; b++) raw[b] = 8'($urandom);

        // Reset with arbitrary pins
        for (int k = 0; k < 3; k++) stepEdge();
        for (int b = 0; b < 8; b++) checkValue("reset_out", dip_out[b], 8'hFF);
`ifdef DIP_DEBOUNCE_STROBE_EN
        checkValue("reset_strobe", {7'd0, sw_changed}, 8'h00);
`endif

        // Clean change on bank 3
        for (int b = 0; b < 8; b++) applyStimulus(b, 8'hFF);
        applyStimulus(3, 8'hA5);
        reset = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            stepEdge();
            if (e == 5) checkValue("clean_E5", dip_out[3], 8'hFF);
            if (e == 6) checkValue("clean_E6", dip_out[3], 8'hA5);
`ifdef DIP_DEBOUNCE_STROBE_EN
            if (e == 6) checkValue("clean_mask_E6", sw_changed_mask, 8'h08);
            if (e == 7) checkValue("clean_mask_E7", sw_changed_mask, 8'h00);
`endif
        end

        // Bounce on bank 0
        applyStimulus(0, 8'h00);
        for (int k = 0; k < 3; k++) stepEdge();
        applyStimulus(0, 8'hFF);
        stepEdge();
        applyStimulus(0, 8'h00);
        for (int e = 0; e <= 7; e++) begin
            stepEdge();
            if (e == 5) checkValue("bounce_E5", dip_out[0], 8'hFF);
            if (e == 6) checkValue("bounce_E6", dip_out[0], 8'h00);
        end

        // Candidate change mid-count on bank 5
        applyStimulus(5, 8'h0F);
        for (int k = 0; k < 3; k++) stepEdge();
        applyStimulus(5, 8'hF0);
        for (int e = 0; e <= 7; e++) begin
            stepEdge();
            if (e == 5) checkValue("cand_E5", dip_out[5], 8'hFF);
            if (e == 6) checkValue("cand_E6", dip_out[5], 8'hF0);
        end

        // Simultaneous banks 1 and 7
        applyStimulus(1, 8'h12);
        applyStimulus(7, 8'h7E);
        for (int e = 0; e <= 7; e++) begin
            stepEdge();
            if (e == 6) checkValue("simul_b1", dip_out[1], 8'h12);
            if (e == 6) checkValue("simul_b7", dip_out[7], 8'h7E);
`ifdef DIP_DEBOUNCE_STROBE_EN
            if (e == 6) checkValue("simul_mask", sw_changed_mask, 8'h82);
`endif
        end

        // Reset mid-count on bank 2
        applyStimulus(2, 8'h3C);
        for (int k = 0; k < 3; k++) stepEdge();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) stepEdge();
        checkValue("midreset_out2", dip_out[2], 8'hFF);
        reset = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            stepEdge();
            if (e == 5) checkValue("midreset_E5", dip_out[2], 8'hFF);
            if (e == 6) checkValue("midreset_E6", dip_out[2], 8'h3C);
        end

        // Randomized pins with occasional reset
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 99) != 0);
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0: applyStimulus(b, 8'hFF);
                        1: applyStimulus(b, 8'h00);
                        2: applyStimulus(b, raw[b] ^ 8'h01);
                        default: applyStimulus(b, 8'($urandom));
                    endcase
                end
            end
            stepEdge();
        end

        reset = 1'b1;
        for (int k = 0; k < 10; k++) stepEdge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
